fifo_wr_arbiter: RTL

Round-robin write-side arbiter that shares one FIFO write port among `NUM_REQ` producers. It sits between the producers and the `fifo_top` write interface in the `wr_clk` domain. It grants one requester at a time for a burst of up to `MAX_BURST` words and gates pushes with the FIFO `full` flag, so the FIFO is never written while full.

---
 rtl/fifo_wr_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bursts of <= MAX_BURST.
// Define FIFO_ARB_STATS_EN to build the words_total push counter; otherwise it is tied to zero.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          full,
  output logic                          push,
  output logic [DATA_WIDTH-1:0]         push_data,
  output logic                          busy,
  output logic [15:0]                   words_total
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state;
  logic [PtrW-1:0] rr_ptr;
  logic [CntW-1:0] burst_cnt;
  logic            win_found;
  logic [PtrW-1:0] win_idx;
  logic            req_g;

  // First requester at or after rr_ptr+1, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!win_found && req[i] && (i == (32'(rr_ptr) + k) % NUM_REQ)) begin
          win_found = 1'b1;
          win_idx   = PtrW'(i);
        end
      end
    end
  end

  // gnt is zero outside BURST, so the mux and push fall to zero when idle.
  always_comb begin
    push_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) push_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    req_g = |(req & gnt);
    push  = (state == StBurst) && req_g && !full;
    ack   = gnt & {NUM_REQ{push}};
    busy  = (state == StBurst);
  end

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      state     <= StIdle;
      gnt       <= '0;
      rr_ptr    <= PtrW'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (win_found) begin
            gnt       <= NUM_REQ'(1) << win_idx;
            rr_ptr    <= win_idx;
            burst_cnt <= '0;
            state     <= StBurst;
          end
        end
        StBurst: begin
          if (push) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == CntW'(MAX_BURST - 1)) begin
              gnt   <= '0;
              state <= StIdle;
            end
          end else if (!req_g) begin
            gnt   <= '0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] words_cnt;

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      words_cnt <= '0;
    end else if (push) begin
      words_cnt <= words_cnt + 16'd1;
    end
  end

  assign words_total = words_cnt;
`else
  assign words_total = 16'h0000;
`endif

endmodule
